// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and the manager FSM state encoding
package axi_lite_pkg;
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction
endpackage

// File: rtl/axi_lite_valid_hold.sv
// axi_lite_valid_hold: VALID set on start, cleared on handshake, with payload latch
module axi_lite_valid_hold #(
  parameter int W = 32
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         start,
  input  logic         clr,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic         done,
  output logic [W-1:0] dout
);
  // done remembers a completed handshake until the transaction retires
  always_ff @(posedge ACLK)
    if (!ARESETn) begin
      valid <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
    end else begin
      valid <= start ? 1'b1 : valid && !ready;
      done  <= start ? 1'b0 : (done || (valid && ready)) && !clr;
      dout  <= start ? din : (clr ? '0 : dout);
    end
endmodule

// File: rtl/axi_lite_manager.sv
// axi_lite_manager: single-outstanding AXI4-Lite initiator for local commands.
// Define AXI_MGR_ERRCNT_EN to add a saturating SLVERR/DECERR counter (err_count).
module axi_lite_manager
  import axi_lite_pkg::*;
#(
  parameter int ABUS_SIZE = 5,
  parameter int DBUS_SIZE = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ABUS_SIZE-1:0] cmd_addr,
  input  logic [DBUS_SIZE-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [DBUS_SIZE-1:0] rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic [ABUS_SIZE-1:0] AWADDR,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [DBUS_SIZE-1:0] WDATA,
  output logic                 WVALID,
  input  logic                 WREADY,
  input  logic [1:0]           BRESP,
  input  logic                 BVALID,
  output logic                 BREADY,
  output logic [ABUS_SIZE-1:0] ARADDR,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [DBUS_SIZE-1:0] RDATA,
  input  logic [1:0]           RRESP,
  input  logic                 RVALID,
`ifdef AXI_MGR_ERRCNT_EN
  output logic [15:0]          err_count,
`endif
  output logic                 RREADY
);
  state_t state, state_nx;
  logic cmd_fire, start_wr, start_rd, clr;
  logic aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs, b_hs, r_hs, wr_ok;

  assign cmd_ready = ARESETn && state == S_IDLE;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign start_wr  = cmd_fire && cmd_write;
  assign start_rd  = cmd_fire && !cmd_write;
  assign clr       = state == S_RSP && rsp_ready;
  assign BREADY    = state == S_WR_RESP;
  assign RREADY    = state == S_RD_RESP;
  assign rsp_valid = state == S_RSP;
  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign ar_hs     = ARVALID && ARREADY;
  assign b_hs      = BREADY && BVALID;
  assign r_hs      = RREADY && RVALID;
  // AW and W may complete in different cycles; either order is fine
  assign wr_ok     = (aw_done || aw_hs) && (w_done || w_hs);

  axi_lite_valid_hold #(.W(ABUS_SIZE)) u_aw (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start_wr), .clr(clr), .ready(AWREADY),
    .din(cmd_addr), .valid(AWVALID), .done(aw_done), .dout(AWADDR)
  );
  axi_lite_valid_hold #(.W(DBUS_SIZE)) u_w (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start_wr), .clr(clr), .ready(WREADY),
    .din(cmd_wdata), .valid(WVALID), .done(w_done), .dout(WDATA)
  );
  axi_lite_valid_hold #(.W(ABUS_SIZE)) u_ar (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start_rd), .clr(clr), .ready(ARREADY),
    .din(cmd_addr), .valid(ARVALID), .done(ar_done), .dout(ARADDR)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    state_nx = cmd_fire ? (cmd_write ? S_WR_REQ : S_RD_REQ) : S_IDLE;
      S_WR_REQ:  state_nx = wr_ok ? S_WR_RESP : S_WR_REQ;
      S_WR_RESP: state_nx = b_hs ? S_RSP : S_WR_RESP;
      S_RD_REQ:  state_nx = (ar_done || ar_hs) ? S_RD_RESP : S_RD_REQ;
      S_RD_RESP: state_nx = r_hs ? S_RSP : S_RD_RESP;
      S_RSP:     state_nx = rsp_ready ? S_IDLE : S_RSP;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK)
    if (!ARESETn) begin
      state     <= S_IDLE;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else begin
      state     <= state_nx;
      rsp_write <= b_hs ? 1'b1 : (r_hs || clr) ? 1'b0 : rsp_write;
      rsp_rdata <= r_hs ? RDATA : (b_hs || clr) ? '0 : rsp_rdata;
      rsp_resp  <= b_hs ? BRESP : r_hs ? RRESP : clr ? 2'b00 : rsp_resp;
    end

`ifdef AXI_MGR_ERRCNT_EN
  logic err_hit;
  assign err_hit = (b_hs && resp_is_err(BRESP)) || (r_hs && resp_is_err(RRESP));
  always_ff @(posedge ACLK)
    if (!ARESETn) err_count <= 16'h0;
    else if (err_hit && err_count != 16'hFFFF) err_count <= err_count + 16'h1;
`endif
endmodule

// File: tb/tb_axi_lite_manager.sv
// tb_axi_lite_manager: randomized bench against a cycle-schedule model of the manager
module tb_axi_lite_manager;
  import axi_lite_pkg::*;
  logic ACLK = 1'b0;
  logic ARESETn;
  logic cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_write;
  logic [4:0] cmd_addr, AWADDR, ARADDR;
  logic [31:0] cmd_wdata, rsp_rdata, WDATA, RDATA;
  logic [1:0] rsp_resp, BRESP, RRESP;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
`ifdef AXI_MGR_ERRCNT_EN
  logic [15:0] err_count;
  int exp_err;
`endif
  logic [31:0] mem [32];
  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_manager #(.ABUS_SIZE(5), .DBUS_SIZE(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID),
`ifdef AXI_MGR_ERRCNT_EN
    .err_count(err_count),
`endif
    .RREADY(RREADY)
  );

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
    BRESP = '0; RRESP = '0; RDATA = '0;
  endtask

  // One transaction: handshake cycles come from the chosen delays, all counted from the accept edge
  task automatic run_txn(input bit wr, input logic [4:0] a, input logic [31:0] d, input int d1,
                         input int d2, input int v_at, input int hold, input logic [1:0] resp);
    int cr, hb, last;
    logic [6:0] got, exp;
    logic [31:0] exp_rd;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_before_cmd got %b exp 1", cmd_ready); end
    cr = wr ? 1 + ((d1 > d2) ? d1 : d2) : 1 + d1;
    hb = (v_at > cr + 1) ? v_at : cr + 1;
    last = hb + 2 + hold;
    exp_rd = wr ? 32'h0 : mem[a];
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge ACLK);
    for (int c = 1; c <= last; c++) begin
      @(negedge ACLK);
      if (c == 1) begin cmd_valid = 0; cmd_addr = 5'($urandom); cmd_wdata = $urandom; end
      got = {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, cmd_ready};
      exp = {wr && c <= 1 + d1, wr && c <= 1 + d2, !wr && c <= 1 + d1, wr && c > cr && c <= hb,
             !wr && c > cr && c <= hb, c > hb && c <= hb + 1 + hold, c == last};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL handshake c=%0d aw,w,ar,b,r,rsp,cmd got %b exp %b", c, got, exp);
      end
      if (exp[6:4] != 3'b000) begin
        checks++;
        if ({AWADDR, WDATA, ARADDR} !== {wr ? a : 5'h0, wr ? d : 32'h0, wr ? 5'h0 : a}) begin
          errors++;
          $display("FAIL payload c=%0d got %h/%h/%h", c, AWADDR, WDATA, ARADDR);
        end
      end
      if (exp[1]) begin
        checks++;
        if ({rsp_write, rsp_rdata, rsp_resp} !== {wr, exp_rd, resp}) begin
          errors++;
          $display("FAIL response c=%0d got w=%b d=%h r=%b exp w=%b d=%h r=%b",
                   c, rsp_write, rsp_rdata, rsp_resp, wr, exp_rd, resp);
        end
      end
      if (c == last) begin
        checks++;
        if ({AWADDR, WDATA, ARADDR} !== 42'h0) begin
          errors++;
          $display("FAIL idle_addr got %h/%h/%h exp 0", AWADDR, WDATA, ARADDR);
        end
      end
      AWREADY = wr && c == 1 + d1;
      WREADY  = wr && c == 1 + d2;
      ARREADY = !wr && c == 1 + d1;
      BVALID  = wr && c >= v_at && c <= hb;
      RVALID  = !wr && c >= v_at && c <= hb;
      BRESP   = resp;
      RRESP   = resp;
      RDATA   = RVALID ? mem[a] : $urandom;
      rsp_ready = c >= hb + 1 + hold && c < last;
    end
    if (wr) mem[a] = d;
`ifdef AXI_MGR_ERRCNT_EN
    if (resp[1] && exp_err < 65535) exp_err++;
    checks++;
    if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL err_count got %0d exp %0d", err_count, exp_err); end
`endif
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    ARESETn = 0;
    idle_inputs();
    @(negedge ACLK);
    checks++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, cmd_ready, rsp_write, rsp_rdata,
         rsp_resp, AWADDR, WDATA, ARADDR} !== 82'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b%b%b%b%b rsp=%b cmd=%b", AWVALID, WVALID, ARVALID,
               BREADY, RREADY, rsp_valid, cmd_ready);
    end
`ifdef AXI_MGR_ERRCNT_EN
    exp_err = 0;
    checks++;
    if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
`endif
    ARESETn = 1;
    @(negedge ACLK);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset cmd_ready,rsp_valid got %b exp 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_write_zero_wait();
    run_txn(1, 5'h03, 32'hDEADBEEF, 0, 0, 1, 0, RESP_OKAY);
  endtask

  task automatic test_read_back();
    run_txn(0, 5'h03, 32'h0, 0, 0, 1, 0, RESP_OKAY);
    checks++;
    if (mem[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL readback_model got %h exp deadbeef", mem[3]); end
  endtask

  task automatic test_delayed_ready();
    run_txn(1, 5'h0A, 32'h12345678, 2, 4, 1, 0, RESP_EXOKAY);
    run_txn(1, 5'h0B, 32'hCAFEF00D, 3, 0, 7, 0, RESP_SLVERR);
  endtask

  task automatic test_rsp_stall();
    run_txn(0, 5'h0A, 32'h0, 1, 0, 2, 5, RESP_OKAY);
    run_txn(1, 5'h11, 32'hA5A55A5A, 0, 0, 3, 0, RESP_OKAY);
  endtask

  task automatic test_back_to_back();
    run_txn(1, 5'h1F, 32'h0BADF00D, 0, 0, 1, 0, RESP_DECERR);
    run_txn(0, 5'h1F, 32'h0, 0, 0, 1, 0, RESP_OKAY);
    run_txn(0, 5'h11, 32'h0, 0, 0, 1, 0, RESP_SLVERR);
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h05; cmd_wdata = 32'h55667788;
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 0; AWREADY = 1; WREADY = 1;
    @(negedge ACLK);
    checks++;
    if (BREADY !== 1'b1) begin errors++; $display("FAIL mid_bready got %b exp 1", BREADY); end
    AWREADY = 0; WREADY = 0; ARESETn = 0; BVALID = 1; BRESP = RESP_SLVERR;
    mem[5] = 32'h55667788;
    @(negedge ACLK);
    checks++;
    if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, cmd_ready, AWADDR, WDATA} !== 44'h0) begin
      errors++;
      $display("FAIL mid_reset got v=%b%b%b%b%b rsp=%b cmd=%b", AWVALID, WVALID, ARVALID, BREADY,
               RREADY, rsp_valid, cmd_ready);
    end
    BVALID = 0; ARESETn = 1;
`ifdef AXI_MGR_ERRCNT_EN
    exp_err = 0;
`endif
    @(negedge ACLK);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_resp} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_recover got %b exp 1000", {cmd_ready, rsp_valid, rsp_resp});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(1, 6), $urandom_range(0, 2), 2'($urandom));
  endtask

`ifdef AXI_MGR_ERRCNT_EN
  task automatic test_errcnt();
    test_reset();
    run_txn(0, 5'h02, 32'h0, 0, 0, 1, 0, RESP_SLVERR);
    run_txn(0, 5'h04, 32'h0, 1, 0, 3, 0, RESP_SLVERR);
    run_txn(0, 5'h06, 32'h0, 0, 0, 1, 1, RESP_OKAY);
    run_txn(0, 5'h08, 32'h0, 2, 0, 1, 0, RESP_SLVERR);
    checks++;
    if (err_count !== 16'd3) begin errors++; $display("FAIL errcnt_three got %0d exp 3", err_count); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    ARESETn = 0;
    idle_inputs();
`ifdef AXI_MGR_ERRCNT_EN
    exp_err = 0;
`endif
    test_reset();
    test_write_zero_wait();
    test_read_back();
    test_delayed_ready();
    test_rsp_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef AXI_MGR_ERRCNT_EN
    test_errcnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_manager.md
# axi_lite_manager

AXI4-Lite manager (initiator) that converts single-beat commands from local logic into AXI4-Lite read or write transactions, drives the address/data channels, and returns the response. It is the initiator counterpart to the team's AXI4-Lite subordinator memory block and connects directly to its five channels. One transaction is outstanding at a time.

## Interface
- ABUS_SIZE, 5: AXI address width in bits.
- DBUS_SIZE, 32: AXI data width in bits.

- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ABUS_SIZE  target address.
- cmd_wdata  in  DBUS_SIZE  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DBUS_SIZE  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- AWADDR/AWVALID out, AWREADY in; WDATA/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out. Widths ABUS_SIZE, DBUS_SIZE, 2, 1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch addr/data/write; go to WR_REQ (assert AWVALID and WVALID) or RD_REQ (assert ARVALID).
- WR_REQ: AWVALID and WVALID tracked independently; each deasserts the cycle after its own handshake. Exit to WR_RESP when both handshakes are complete (same or different cycles).
- WR_RESP: BREADY=1. On BVALID, capture BRESP, rsp_write=1, rsp_rdata=0; go to RSP.
- RD_REQ: ARVALID held until ARREADY; go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA/RRESP, rsp_write=0; go to RSP.
- RSP: rsp_valid=1, held with stable data until rsp_ready; then IDLE.
- Every VALID, once asserted, stays high with stable payload until its handshake. VALIDs never depend combinationally on READYs.
- AWADDR/WDATA/ARADDR drive latched values; they are 0 in IDLE.

## Timing
- Reset: cmd_ready=0 during reset and 1 the first cycle after; all VALID/READY outputs 0, rsp_* 0, AWADDR/WDATA/ARADDR 0, state IDLE.
- Reset mid-transaction: immediate return to IDLE, all outputs to reset values, captured response discarded.
- Command accepted at edge N: request VALIDs high in cycle N+1.
- Handshakes sampled at edges. AW+W accepted at N+1 gives BREADY high N+2. BVALID at N+2 gives rsp_valid N+3. Minimum write and read latency is 3 cycles from command to rsp_valid.
- BVALID/RVALID arriving while the request phase is still open are ignored (BREADY/RREADY low).
- rsp_ready held high: RSP lasts one cycle; cmd_ready high the next cycle.
- No timeout; a silent subordinate stalls the block indefinitely.

## Configuration
- AXI_MGR_ERRCNT_EN defined: adds output err_count (16 bits) counting responses with resp[1]=1 (SLVERR/DECERR). The count increments on the B/R handshake, saturates at 16'hFFFF, and clears only on reset.
- Not defined: err_count port and counter absent. Behaviour is otherwise identical.

## Structure
- Shared package axi_lite_pkg holds the state encoding for this FSM plus the response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10 and RESP_DECERR=2'b11.
- One sub-module, axi_lite_valid_hold: a set-on-start, clear-on-handshake VALID register with payload latch. It is instantiated for AW, W and AR.

## Test plan
- Reset then write addr 5'h03 data 32'hDEADBEEF to a zero-wait subordinator: AW/W handshake together, and rsp_valid appears 3 cycles after command with rsp_write=1 and rsp_resp equal to the returned BRESP.
- Write then read addr 5'h03: rsp_rdata=32'hDEADBEEF, rsp_write=0.
- AWREADY delayed 2 cycles and WREADY delayed 4: WVALID stays high until its handshake, AWVALID drops after its own, and BREADY rises only after both.
- Hold rsp_ready low 5 cycles: rsp_valid and data stay stable and cmd_ready stays 0; after release, the next command is accepted.
- Assert ARESETn=0 during WR_RESP: the next cycle shows all VALID/READY at 0, IDLE, no rsp_valid.
- With AXI_MGR_ERRCNT_EN, three reads answered RRESP=2'b10 and one answered 2'b00 give err_count=3.
